// File: rtl/reservation_station_param.sv
// Unified reservation station: dual-slot dispatch, physical-register scoreboard
// with writeback wakeup, oldest-ready issue per port selected by an age matrix.
module reservation_station_param #(
  parameter int DEPTH   = 32,
  parameter int PREG_W  = 6,
  parameter int ROB_W   = 5,
  parameter int NUM_ALU = 2,
  parameter int NUM_WB  = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [1:0]                    disp_valid,
  output logic                          disp_ready,
  input  logic [2*PREG_W-1:0]           disp_rs1,
  input  logic [2*PREG_W-1:0]           disp_rs2,
  input  logic [2*PREG_W-1:0]           disp_rd,
  input  logic [63:0]                   disp_imm,
  input  logic [5:0]                    disp_alu_op,
  input  logic [13:0]                   disp_opcode,
  input  logic [NUM_WB-1:0]             wb_valid,
  input  logic [NUM_WB*PREG_W-1:0]      wb_preg,
  output logic [NUM_ALU:0]              iss_valid,
  input  logic [NUM_ALU:0]              iss_ready,
  output logic [(NUM_ALU+1)*7-1:0]      iss_opcode,
  output logic [(NUM_ALU+1)*3-1:0]      iss_alu_op,
  output logic [(NUM_ALU+1)*PREG_W-1:0] iss_rd,
  output logic [(NUM_ALU+1)*PREG_W-1:0] iss_rs1,
  output logic [(NUM_ALU+1)*PREG_W-1:0] iss_rs2,
  output logic [(NUM_ALU+1)*32-1:0]     iss_imm,
  output logic [(NUM_ALU+1)*ROB_W-1:0]  iss_rob,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          full
);
  localparam int NP    = NUM_ALU + 1;
  localparam int IW    = $clog2(DEPTH);
  localparam int CW    = IW + 1;
  localparam int PW    = $clog2(NP);
  localparam int NPREG = 1 << PREG_W;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [DEPTH-1:0] ONE = 1;

  // entry state; e_older[i][j] = 1 means entry j is older than entry i
  logic [DEPTH-1:0]  e_vld, e_r1, e_r2;
  logic [DEPTH-1:0]  e_older [DEPTH];
  logic [6:0]        e_op    [DEPTH];
  logic [2:0]        e_alu   [DEPTH];
  logic [PREG_W-1:0] e_rd    [DEPTH];
  logic [PREG_W-1:0] e_rs1   [DEPTH];
  logic [PREG_W-1:0] e_rs2   [DEPTH];
  logic [31:0]       e_imm   [DEPTH];
  logic [ROB_W-1:0]  e_rob   [DEPTH];
  logic [PW-1:0]     e_port  [DEPTH];
  logic [NPREG-1:0]  sb;
  logic [PW-1:0]     rr;
  logic [ROB_W-1:0]  rob_cnt;
  logic [NP-1:0]     lock_vld;
  logic [IW-1:0]     lock_idx [NP];

  logic [6:0]        d_op  [2];
  logic [PREG_W-1:0] d_rd  [2];
  logic [PREG_W-1:0] d_rs1 [2];
  logic [PREG_W-1:0] d_rs2 [2];
  logic [1:0]        acc, d_r1, d_r2;
  logic [IW-1:0]     a_idx [2];
  logic [PW-1:0]     d_port [2];
  logic [PW-1:0]     rr_nxt;
  logic [IW-1:0]     f0, f1;
  logic              f0_ok, f1_ok, hit;
  logic [PREG_W-1:0] src;
  logic [DEPTH-1:0]  cand;
  logic [IW-1:0]     sel_idx [NP];
  logic [CW-1:0]     n_iss, count_nxt;

  // Dispatch decode: legality, lowest-free allocation, port steering, operand readiness
  always_comb begin
    f0 = '0; f1 = '0; f0_ok = 1'b0; f1_ok = 1'b0;
    hit = 1'b0; src = '0;
    d_r1 = '0; d_r2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!e_vld[i]) begin
        if (!f0_ok) begin f0 = IW'(i); f0_ok = 1'b1; end
        else if (!f1_ok) begin f1 = IW'(i); f1_ok = 1'b1; end
      end
    end
    for (int s = 0; s < 2; s++) begin
      d_op[s]  = disp_opcode[s*7 +: 7];
      d_rd[s]  = disp_rd[s*PREG_W +: PREG_W];
      d_rs1[s] = disp_rs1[s*PREG_W +: PREG_W];
      d_rs2[s] = disp_rs2[s*PREG_W +: PREG_W];
      acc[s]   = disp_valid[s] && disp_ready &&
                 (d_op[s] inside {OP_R, OP_S, OP_I, OP_L});
    end
    a_idx[0] = f0;
    a_idx[1] = acc[0] ? f1 : f0;
    rr_nxt = rr;
    for (int s = 0; s < 2; s++) begin
      if (d_op[s] == OP_L || d_op[s] == OP_S) begin
        d_port[s] = PW'(NUM_ALU);
      end else begin
        d_port[s] = rr_nxt;
        if (acc[s]) rr_nxt = (rr_nxt == PW'(NUM_ALU-1)) ? '0 : rr_nxt + 1'b1;
      end
    end
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 2; k++) begin
        src = (k == 0) ? d_rs1[s] : d_rs2[s];
        hit = sb[src];
        for (int w = 0; w < NUM_WB; w++)
          if (wb_valid[w] && wb_preg[w*PREG_W +: PREG_W] == src) hit = 1'b1;
        // slot 1 cannot see the result slot 0 is about to produce
        if (s == 1 && acc[0] && d_op[0] != OP_S && src == d_rd[0]) hit = 1'b0;
        if (src == '0) hit = 1'b1;
        if (k == 0) d_r1[s] = hit;
        else        d_r2[s] = (d_op[s] == OP_R || d_op[s] == OP_S) ? hit : 1'b1;
      end
    end
  end

  // Issue select: per port the oldest ready entry, or the entry held from a stalled cycle
  always_comb begin
    iss_valid = '0; iss_opcode = '0; iss_alu_op = '0; iss_rd = '0;
    iss_rs1 = '0; iss_rs2 = '0; iss_imm = '0; iss_rob = '0;
    cand = '0;
    for (int p = 0; p < NP; p++) begin
      sel_idx[p] = '0;
      for (int i = 0; i < DEPTH; i++)
        cand[i] = e_vld[i] && e_r1[i] && e_r2[i] && (e_port[i] == PW'(p));
      for (int i = 0; i < DEPTH; i++)
        if (cand[i] && ((e_older[i] & cand) == '0)) begin
          sel_idx[p] = IW'(i);
          iss_valid[p] = 1'b1;
        end
      if (lock_vld[p]) begin
        sel_idx[p] = lock_idx[p];
        iss_valid[p] = 1'b1;
      end
      if (iss_valid[p]) begin
        iss_opcode[p*7 +: 7]          = e_op[sel_idx[p]];
        iss_alu_op[p*3 +: 3]          = e_alu[sel_idx[p]];
        iss_rd[p*PREG_W +: PREG_W]    = e_rd[sel_idx[p]];
        iss_rs1[p*PREG_W +: PREG_W]   = e_rs1[sel_idx[p]];
        iss_rs2[p*PREG_W +: PREG_W]   = e_rs2[sel_idx[p]];
        iss_imm[p*32 +: 32]           = e_imm[sel_idx[p]];
        iss_rob[p*ROB_W +: ROB_W]     = e_rob[sel_idx[p]];
      end
    end
  end

  // Occupancy after this edge: allocations in, handshakes out
  always_comb begin
    n_iss = '0;
    for (int p = 0; p < NP; p++) n_iss = n_iss + CW'(iss_valid[p] && iss_ready[p]);
    count_nxt = count + CW'(acc[0]) + CW'(acc[1]) - n_iss;
  end

  // State update: flush dominates; else wakeup, free, allocate, scoreboard
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_vld <= '0; e_r1 <= '0; e_r2 <= '0; sb <= '1; rr <= '0; rob_cnt <= '0;
      count <= '0; disp_ready <= 1'b1; full <= 1'b0; lock_vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        e_older[i] <= '0; e_op[i] <= '0; e_alu[i] <= '0; e_rd[i] <= '0;
        e_rs1[i] <= '0; e_rs2[i] <= '0; e_imm[i] <= '0; e_rob[i] <= '0; e_port[i] <= '0;
      end
      for (int p = 0; p < NP; p++) lock_idx[p] <= '0;
    end else if (flush) begin
      e_vld <= '0; sb <= '1; rr <= '0; rob_cnt <= '0;
      count <= '0; disp_ready <= 1'b1; full <= 1'b0; lock_vld <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        for (int w = 0; w < NUM_WB; w++)
          if (wb_valid[w]) begin
            if (e_rs1[i] == wb_preg[w*PREG_W +: PREG_W]) e_r1[i] <= 1'b1;
            if (e_rs2[i] == wb_preg[w*PREG_W +: PREG_W]) e_r2[i] <= 1'b1;
          end
      for (int w = 0; w < NUM_WB; w++)
        if (wb_valid[w]) sb[wb_preg[w*PREG_W +: PREG_W]] <= 1'b1;
      for (int p = 0; p < NP; p++) begin
        if (iss_valid[p] && iss_ready[p]) e_vld[sel_idx[p]] <= 1'b0;
        lock_vld[p] <= iss_valid[p] && !iss_ready[p];
        lock_idx[p] <= sel_idx[p];
      end
      for (int s = 0; s < 2; s++) begin
        if (acc[s]) begin
          e_vld[a_idx[s]]  <= 1'b1;
          e_r1[a_idx[s]]   <= d_r1[s];
          e_r2[a_idx[s]]   <= d_r2[s];
          e_op[a_idx[s]]   <= d_op[s];
          e_alu[a_idx[s]]  <= disp_alu_op[s*3 +: 3];
          e_rd[a_idx[s]]   <= d_rd[s];
          e_rs1[a_idx[s]]  <= d_rs1[s];
          e_rs2[a_idx[s]]  <= d_rs2[s];
          e_imm[a_idx[s]]  <= disp_imm[s*32 +: 32];
          e_port[a_idx[s]] <= d_port[s];
          e_rob[a_idx[s]]  <= rob_cnt + ROB_W'(s == 1 && acc[0]);
          // a reused slot must not appear older than anything still queued
          for (int r = 0; r < DEPTH; r++) e_older[r][a_idx[s]] <= 1'b0;
          e_older[a_idx[s]] <= (s == 1 && acc[0]) ? (e_vld | (ONE << a_idx[0])) : e_vld;
          // clear after the wakeup set so a same-cycle rename wins
          if (d_op[s] != OP_S && d_rd[s] != '0) sb[d_rd[s]] <= 1'b0;
        end
      end
      rob_cnt    <= rob_cnt + ROB_W'(acc[0]) + ROB_W'(acc[1]);
      rr         <= rr_nxt;
      count      <= count_nxt;
      disp_ready <= (count_nxt <= CW'(DEPTH-2));
      full       <= !(count_nxt <= CW'(DEPTH-2));
    end
  end
endmodule
